// File: rtl/bit_injector.sv
// Bit-serial replacement-data injector. Arms with a word and a lane mask, then
// at the next frame start shifts the word out MSB first, one bit per edge of
// the synchronized bus clock. The word is replicated on every lane and the
// lane mask drives the per-lane select of the downstream output multiplexer.
module bit_injector #(
  parameter int WIDTH            = 4,
  parameter int DATA_BITS        = 8,
  parameter int SHIFT_ON_FALLING = 1
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic [WIDTH-1:0]     lane_mask,
  input  logic                 data_valid,
  output logic                 data_ready,
  input  logic                 frame_active,
  input  logic                 bus_clk,
  output logic [WIDTH-1:0]     fake_line,
  output logic [WIDTH-1:0]     select_line,
  output logic                 busy,
  output logic                 done_pulse,
  output logic                 abort_pulse
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);
  // Counter value seen in the cycle of the final (completing) shift edge.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_BITS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]           r_state;
  logic                 r_bus_clk_q;
  logic                 r_frame_q;
  logic [DATA_BITS-1:0] r_shift;
  logic [WIDTH-1:0]     r_mask;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_fake;
  logic [WIDTH-1:0]     r_select;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_abort;

  logic w_shift_edge;
  logic w_frame_start;
  logic w_last_edge;

  // Edge detection against the one-cycle-old copies of the synchronized inputs.
  assign w_shift_edge  = (SHIFT_ON_FALLING != 0) ? (~bus_clk & r_bus_clk_q)
                                                 : (bus_clk & ~r_bus_clk_q);
  assign w_frame_start = frame_active & ~r_frame_q;
  assign w_last_edge   = w_shift_edge && (r_cnt == LAST_CNT);

  // Ready is a pure state decode so a load can be accepted in the first IDLE cycle.
  assign data_ready  = (r_state == ST_IDLE);
  assign fake_line   = r_fake;
  assign select_line = r_select;
  assign busy        = r_busy;
  assign done_pulse  = r_done;
  assign abort_pulse = r_abort;

  // Input history registers for edge detection.
  always_ff @(posedge sys_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      r_bus_clk_q <= 1'b0;
      r_frame_q   <= 1'b0;
    end else begin
      r_bus_clk_q <= bus_clk;
      r_frame_q   <= frame_active;
    end
  end

  // Control FSM plus the registered datapath it steers.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      // NOTE: the word and mask registers are reset too; they are small and a
      // known value after reset keeps post-reset behaviour fully deterministic.
      r_state  <= ST_IDLE;
      r_shift  <= '0;
      r_mask   <= '0;
      r_cnt    <= '0;
      r_fake   <= '0;
      r_select <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_abort  <= 1'b0;
    end else begin
      // Pulses last exactly one cycle unless re-asserted below.
      r_done  <= 1'b0;
      r_abort <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          // Any frame start seen in this cycle is deliberately ignored.
          if (data_valid) begin
            r_shift <= data_in;
            r_mask  <= lane_mask;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_ARMED;
          end
        end

        ST_ARMED: begin
          // Only a fresh 0->1 frame transition starts injection, never a frame
          // that was already running when the word was loaded.
          if (w_frame_start) begin
            r_select <= r_mask;
            r_fake   <= {WIDTH{r_shift[DATA_BITS-1]}};
            r_state  <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (w_last_edge) begin
            // Completion has priority over a simultaneous frame end.
            r_cnt    <= r_cnt + CNT_W'(1);
            r_shift  <= {r_shift[DATA_BITS-2:0], 1'b0};
            r_select <= '0;
            r_fake   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= ST_DONE;
          end else if (!frame_active) begin
            r_select <= '0;
            r_fake   <= '0;
            r_busy   <= 1'b0;
            r_abort  <= 1'b1;
            r_state  <= ST_IDLE;
          end else if (w_shift_edge) begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_shift <= {r_shift[DATA_BITS-2:0], 1'b0};
            r_fake  <= {WIDTH{r_shift[DATA_BITS-2]}};
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state  <= ST_IDLE;
          r_select <= '0;
          r_fake   <= '0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/bit_injector.md
Name: bit_injector

Overview:
- Upstream companion of the output multiplexer; generates its replacement-data lane vector (fake_line → mux in_line1) and per-lane select vector (select_line → mux select_line).
- Accepts a replacement word from the MITM control logic and arms; at the next intercepted frame start, shifts the word out bit-serially, locked to the synchronized bus clock.
- Asserts select only on masked lanes for the duration of the injected word.

Parameters:
- WIDTH, 4: number of bus lanes; width of lane_mask, fake_line, select_line.
- DATA_BITS, 8: bits per injected word; legal range is 2 or more.
- SHIFT_ON_FALLING, 1: 1 advances on falling bus_clk edges, 0 on rising.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  DATA_BITS  replacement word, MSB shifted first.
- lane_mask  in  WIDTH  lanes to override; captured with data_in.
- data_valid  in  1  load request.
- data_ready  out  1  high when idle; load accepted when data_valid and data_ready are both high.
- frame_active  in  1  already-synchronized frame qualifier (e.g. inverted CS).
- bus_clk  in  1  already-synchronized intercepted bus clock.
- fake_line  out  WIDTH  current injected bit replicated on all lanes.
- select_line  out  WIDTH  lane_mask while shifting, else 0.
- busy  out  1  high in ARMED or SHIFT.
- done_pulse  out  1  1-cycle pulse: word fully shifted.
- abort_pulse  out  1  1-cycle pulse: frame ended before word finished.

Behaviour:
- All outputs registered except data_ready, which is decoded from state.
- Reset values:
  - state IDLE, data_ready=1
  - fake_line=0, select_line=0, busy=0, done_pulse=0, abort_pulse=0
  - internal bus_clk and frame_active history registers = 0
  - shift register and bit counter = 0
- Edge detect:
  - bus_clk_q and frame_q are registered copies of their inputs.
  - shift_edge = (~bus_clk & bus_clk_q) if SHIFT_ON_FALLING, else (bus_clk & ~bus_clk_q).
  - frame_start = frame_active & ~frame_q.
- Bit counter width is clog2(DATA_BITS+1).
- FSM states:
  - IDLE: on data_valid & data_ready, latch data_in and lane_mask, clear counter, go to ARMED. data_valid is ignored in every other state.
  - ARMED: busy=1, select_line=0. Wait for frame_start. A frame already active at arming is not used; injection waits for the next frame start. On frame_start, go to SHIFT. From the next cycle, select_line=mask and fake_line={WIDTH{word MSB}}.
  - SHIFT: on each shift_edge, increment the counter and shift the word left; fake_line shows the new MSB the following cycle.
    - On the DATA_BITS-th shift_edge, go to DONE.
    - If frame_active is 0 and that cycle is not the completing edge, go to IDLE. abort_pulse=1, select_line=0, fake_line=0, all on the next cycle.
  - DONE: for one cycle, done_pulse=1, select_line=0, fake_line=0, busy=0; then go to IDLE.
- Latency:
  - First bit valid 1 sys_clk after the frame_start cycle.
  - Each subsequent bit is valid 1 sys_clk after the shift_edge detect cycle.
  - select_line drops 1 sys_clk after the completing edge detect.
- Simultaneous events:
  - Completing edge in the same cycle as frame_active=0: completion wins (done_pulse, no abort_pulse).
  - frame_start in the same cycle as the load is accepted: ignored; ARMED waits for a later start.
- rst mid-operation: on the next sys_clk edge all state returns to reset values. select_line=0 immediately at that edge; no pulse is emitted.
- Back-to-back loads: data_ready is high again in the cycle after DONE or abort.
- The block never drives select_line nonzero outside SHIFT.

Test Plan:
- Reset: hold rst 3 cycles, then release → all outputs 0, data_ready=1; toggling bus_clk and frame_active causes no select activity.
- Nominal (WIDTH=4, DATA_BITS=8, SHIFT_ON_FALLING=1): load 0xA5 with mask 4'b0010, raise frame_active, apply 8 bus_clk periods.
  - select_line=4'b0010 from 1 cycle after frame_start.
  - fake_line lane values 1,0,1,0,0,1,0,1, each as 4'b1111/4'b0000.
  - done_pulse 1 cycle after the 8th falling-edge detect; select_line=0 after.
- Abort: load 0x3C, drop frame_active after 3 falling edges → abort_pulse=1 once, select_line=0 next cycle, no done_pulse, data_ready=1 the following cycle.
- Arm during active frame: frame_active already 1, load 0xFF → no select activity until frame_active goes 0→1; then full injection as in the nominal case.
- Reset mid-shift after 4 edges → select_line=0 and busy=0 at the reset edge, no pulses; a fresh load of 0x81 then injects correctly.
- Busy protection: data_valid with 0x00 during SHIFT of 0xF0 → ignored; output is 0xF0. Edge case: frame_active falls in the same cycle as the 8th edge → done_pulse, not abort_pulse.
